// File: rtl/sprite_path_pkg.sv
// Shared types and default tables for the sprite path mover: direction codes,
// path segments, teleport entries and the controller state encoding.
package sprite_path_pkg;

    localparam logic [1:0] DIR_DR = 2'd0;
    localparam logic [1:0] DIR_DL = 2'd1;
    localparam logic [1:0] DIR_UR = 2'd2;
    localparam logic [1:0] DIR_UL = 2'd3;

    // Table fields are stored wide; consumers keep only X_W+1 bits.
    typedef struct packed {
        logic        kind;
        logic [15:0] k;
        logic [15:0] xmin;
        logic [15:0] xmax;
    } segment_t;

    localparam segment_t SEG_NEVER = '{kind: 1'b0, k: 16'd0, xmin: 16'hFFFF, xmax: 16'd0};

    function automatic segment_t default_segment(input int idx);
        case (idx)
            0:       return '{kind: 1'b0, k: 16'd318, xmin: 16'd96,  xmax: 16'd122};
            1:       return '{kind: 1'b1, k: 16'd31,  xmin: 16'd127, xmax: 16'd181};
            default: return SEG_NEVER;
        endcase
    endfunction

    localparam int NUM_TP = 1;

    typedef struct packed {
        logic [15:0] src_x;
        logic [15:0] src_y;
        logic [15:0] dst_x;
        logic [15:0] dst_y;
    } teleport_t;

    localparam teleport_t TP_TABLE [NUM_TP] = '{
        '{src_x: 16'd123, src_y: 16'd195, dst_x: 16'd127, dst_y: 16'd96}
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_CHECK,
        S_DRAW_BG,
        S_WAIT_BG,
        S_UPDATE,
        S_DRAW_CHAR,
        S_WAIT_CHAR
    } state_t;

endpackage

// File: rtl/path_segment_rom.sv
// Combinational lookup of one path segment by index, fields narrowed to A_W bits.
module path_segment_rom
    import sprite_path_pkg::*;
#(
    parameter int NUM_SEG = 8,
    parameter int IDX_W   = 3,
    parameter int A_W     = 10
) (
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_kind,
    output logic [A_W-1:0]   o_k,
    output logic [A_W-1:0]   o_xmin,
    output logic [A_W-1:0]   o_xmax
);

    logic           w_kind_tab [NUM_SEG];
    logic [A_W-1:0] w_k_tab    [NUM_SEG];
    logic [A_W-1:0] w_xmin_tab [NUM_SEG];
    logic [A_W-1:0] w_xmax_tab [NUM_SEG];

    for (genvar gi = 0; gi < NUM_SEG; gi++) begin : g_seg
        localparam segment_t SEG = default_segment(gi);
        assign w_kind_tab[gi] = SEG.kind;
        assign w_k_tab[gi]    = SEG.k[A_W-1:0];
        assign w_xmin_tab[gi] = SEG.xmin[A_W-1:0];
        assign w_xmax_tab[gi] = SEG.xmax[A_W-1:0];
    end

    // Out-of-table indices fall back to an empty x range, so they never hit.
    always_comb begin
        o_kind = 1'b0;
        o_k    = '0;
        o_xmin = '1;
        o_xmax = '0;
        for (int s = 0; s < NUM_SEG; s++) begin
            if (i_idx == IDX_W'(s)) begin
                o_kind = w_kind_tab[s];
                o_k    = w_k_tab[s];
                o_xmin = w_xmin_tab[s];
                o_xmax = w_xmax_tab[s];
            end
        end
    end

endmodule

// File: rtl/sprite_path_mover.sv
// Tick-paced diagonal sprite mover with segment-table validation and drawer handshake.
// Optional teleport substitution in CALC is enabled by defining PATH_TELEPORT_EN.
module sprite_path_mover
    import sprite_path_pkg::*;
#(
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int NUM_SEG  = 8,
    parameter int START_X  = 96,
    parameter int START_Y  = 222,
    parameter int TICK_DIV = 6250000
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           move_req,
    input  logic [1:0]     dir,
    input  logic           bg_done,
    input  logic           char_done,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           draw_bg,
    output logic           draw_char,
    output logic           busy,
    output logic           move_rejected
);

    localparam int IDX_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int A_W   = X_W + 1;

    state_t           r_state;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [1:0]       r_dir;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;
    logic [X_W-1:0]   r_cx;
    logic [Y_W-1:0]   r_cy;
    logic [IDX_W-1:0] r_seg_idx;
    logic             r_draw_bg;
    logic             r_draw_char;
    logic             r_busy;
    logic             r_move_rejected;

    logic             w_tick;
    logic             w_oob;
    logic [X_W-1:0]   w_cand_x;
    logic [Y_W-1:0]   w_cand_y;
    logic             w_seg_kind;
    logic [A_W-1:0]   w_seg_k;
    logic [A_W-1:0]   w_seg_xmin;
    logic [A_W-1:0]   w_seg_xmax;
    logic [A_W-1:0]   w_cx_e;
    logic [A_W-1:0]   w_cy_e;
    logic [A_W-1:0]   w_sum;
    logic [A_W-1:0]   w_diff;
    logic             w_on_line;
    logic             w_seg_hit;

    assign w_tick = (r_tick_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clock) begin
        if (!resetn || w_tick) r_tick_cnt <= '0;
        else                   r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // dir bit 0 selects x decrement, bit 1 selects y decrement; edges saturate by rejecting.
    assign w_oob    = (r_dir[0] ? (r_x == '0) : (r_x == '1)) ||
                      (r_dir[1] ? (r_y == '0) : (r_y == '1));
    assign w_cand_x = r_dir[0] ? r_x - 1'b1 : r_x + 1'b1;
    assign w_cand_y = r_dir[1] ? r_y - 1'b1 : r_y + 1'b1;

    path_segment_rom #(
        .NUM_SEG (NUM_SEG),
        .IDX_W   (IDX_W),
        .A_W     (A_W)
    ) u_rom (
        .i_idx   (r_seg_idx),
        .o_kind  (w_seg_kind),
        .o_k     (w_seg_k),
        .o_xmin  (w_seg_xmin),
        .o_xmax  (w_seg_xmax)
    );

    assign w_cx_e    = A_W'(r_cx);
    assign w_cy_e    = A_W'(r_cy);
    assign w_sum     = w_cx_e + w_cy_e;
    assign w_diff    = w_cx_e - w_cy_e;
    assign w_on_line = w_seg_kind ? ((w_cx_e >= w_cy_e) && (w_diff == w_seg_k))
                                  : (w_sum == w_seg_k);
    assign w_seg_hit = w_on_line && (w_seg_xmin <= w_cx_e) && (w_cx_e <= w_seg_xmax);

`ifdef PATH_TELEPORT_EN
    logic [NUM_TP-1:0] w_tp_match;
    logic [X_W-1:0]    w_tp_x;
    logic [Y_W-1:0]    w_tp_y;

    for (genvar gi = 0; gi < NUM_TP; gi++) begin : g_tp
        localparam teleport_t TP = TP_TABLE[gi];
        assign w_tp_match[gi] = (w_cand_x == X_W'(TP.src_x)) && (w_cand_y == Y_W'(TP.src_y));
    end

    // Lowest-numbered matching entry wins.
    always_comb begin
        w_tp_x = w_cand_x;
        w_tp_y = w_cand_y;
        for (int t = NUM_TP - 1; t >= 0; t--) begin
            if (w_tp_match[t]) begin
                w_tp_x = X_W'(TP_TABLE[t].dst_x);
                w_tp_y = Y_W'(TP_TABLE[t].dst_y);
            end
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state         <= S_IDLE;
            r_dir           <= '0;
            r_x             <= X_W'(START_X);
            r_y             <= Y_W'(START_Y);
            r_cx            <= '0;
            r_cy            <= '0;
            r_seg_idx       <= '0;
            r_draw_bg       <= 1'b0;
            r_draw_char     <= 1'b0;
            r_busy          <= 1'b0;
            r_move_rejected <= 1'b0;
        end else begin
            r_draw_bg       <= 1'b0;
            r_draw_char     <= 1'b0;
            r_move_rejected <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (move_req && w_tick) begin
                        r_dir   <= dir;
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (w_oob) begin
                        r_move_rejected <= 1'b1;
                        r_busy          <= 1'b0;
                        r_state         <= S_IDLE;
                    end
`ifdef PATH_TELEPORT_EN
                    else if (|w_tp_match) begin
                        r_cx      <= w_tp_x;
                        r_cy      <= w_tp_y;
                        r_draw_bg <= 1'b1;
                        r_state   <= S_DRAW_BG;
                    end
`endif
                    else begin
                        r_cx      <= w_cand_x;
                        r_cy      <= w_cand_y;
                        r_seg_idx <= '0;
                        r_state   <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_seg_hit) begin
                        r_draw_bg <= 1'b1;
                        r_state   <= S_DRAW_BG;
                    end else if (r_seg_idx == IDX_W'(NUM_SEG - 1)) begin
                        r_move_rejected <= 1'b1;
                        r_busy          <= 1'b0;
                        r_state         <= S_IDLE;
                    end else begin
                        r_seg_idx <= r_seg_idx + 1'b1;
                    end
                end
                S_DRAW_BG: r_state <= S_WAIT_BG;
                S_WAIT_BG: begin
                    if (bg_done) begin
                        r_x     <= r_cx;
                        r_y     <= r_cy;
                        r_state <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    r_draw_char <= 1'b1;
                    r_state     <= S_DRAW_CHAR;
                end
                S_DRAW_CHAR: r_state <= S_WAIT_CHAR;
                S_WAIT_CHAR: begin
                    if (char_done) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign x             = r_x;
    assign y             = r_y;
    assign draw_bg       = r_draw_bg;
    assign draw_char     = r_draw_char;
    assign busy          = r_busy;
    assign move_rejected = r_move_rejected;

endmodule
